// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and register map for the UART peripherals.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // Receiver deframer states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Word offsets within the peripheral window.
    localparam logic [7:0] UART_RX_DATA   = 8'd0;
    localparam logic [7:0] UART_RX_STATUS = 8'd1;

    // STATUS register bit positions.
    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVR       = 2;
    localparam int ST_FE        = 3;
    localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/uart_rx_mem_sync_fifo.sv
// Single-clock FIFO holding received bytes; head is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    // A full FIFO drops the incoming byte; an empty one ignores pops.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at the FIFO depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; slots are only read after being written, so resetting the pointers is enough.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_mem.sv
// Memory-mapped 8N1 UART receiver: 16x oversampled deframer feeding a byte FIFO.
module uart_rx_mem
    import uart_pkg::*;
#(
    parameter int DIV     = 39,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [3:0]  writeb,
    input  logic        read,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int CW = $clog2(DIV);

    logic            rx_meta_q, rx_s_q, rx_s_d_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]      sc_q, sc_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ovr_q, ovr_d, fe_q, fe_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            irq_q;
    logic            tick, push_byte, frame_err, pop;
    logic [7:0]      fifo_head;
    logic            fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic [31:0]     status;
    logic            status_wr;

    assign tick = (tick_cnt_q == CW'(DIV - 1));

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_s_d_q  <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_s_d_q  <= rx_s_q;
        end
    end

    // Deframer state and sampling counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            sc_q       <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sc_q       <= sc_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Deframer next state: mid-start check at sample 7, mid-bit samples at 15.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and infers a latch.
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
        sc_d       = sc_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_byte  = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                tick_cnt_d = '0;
                sc_d       = '0;
                if (rx_s_d_q && !rx_s_q) state_d = RX_START;
            end
            RX_START: begin
                if (tick) begin
                    if (sc_q == 4'(UART_OVERSAMPLE / 2 - 1)) begin
                        // A line back high at mid start bit was a glitch.
                        if (!rx_s_q) begin
                            state_d   = RX_DATA;
                            sc_d      = '0;
                            bit_idx_d = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'(UART_OVERSAMPLE - 1)) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    sc_d = sc_q + 4'd1;
                    if (sc_q == 4'(UART_OVERSAMPLE - 1)) begin
                        push_byte = rx_s_q;
                        frame_err = !rx_s_q;
                        state_d   = RX_IDLE;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_byte),
        .din_i   (shift_q),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Bus decode: read mux, pop strobe, sticky-flag set/clear (set wins).
    always_comb begin
        status                                = '0;
        status[ST_NOT_EMPTY]                  = !fifo_empty;
        status[ST_FULL]                       = fifo_full;
        status[ST_OVR]                        = ovr_q;
        status[ST_FE]                         = fe_q;
        status[ST_COUNT_LSB +: FIFO_AW + 1]   = fifo_count;

        pop     = read && (addr == UART_RX_DATA) && !fifo_empty;
        rdata_d = rdata_q;
        if (read) begin
            case (addr)
                UART_RX_DATA:   rdata_d = fifo_empty ? 32'd0 : {24'd0, fifo_head};
                UART_RX_STATUS: rdata_d = status;
                default:        rdata_d = 32'd0;
            endcase
        end

        status_wr = writeb[0] && (addr == UART_RX_STATUS);
        ovr_d = (push_byte && fifo_full) || (ovr_q && !(status_wr && wdata[ST_OVR]));
        fe_d  = frame_err || (fe_q && !(status_wr && wdata[ST_FE]));
    end

    // Registered bus outputs and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            irq_q   <= !fifo_empty;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

    // Write-data and byte-enable bits that no register uses.
    logic unused_bus;
    assign unused_bus = ^{writeb[3:1], wdata[31:4], wdata[1:0]};

endmodule

// File: tb/tb_uart_rx_mem.sv
// Directed-plus-random bench for uart_rx_mem against a queue-based byte model.
module tb_uart_rx_mem;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [3:0]  writeb = '0;
    logic        read = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: received bytes and sticky flags.
    logic [7:0] q_m[$];
    bit         ovr_m = 0;
    bit         fe_m = 0;

    uart_rx_mem #(.DIV(DIV), .FIFO_AW(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .writeb (writeb),
        .read   (read),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit (%0d vectors, %0d miscompares)", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q_m.size();
        return (32'(n) << 8) | (32'(fe_m) << 3) | (32'(ovr_m) << 2)
             | (32'(n == 16) << 1) | 32'(n != 0);
    endfunction

    // All bus/line tasks enter and leave on a falling clock edge.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        if (!stop_ok)           fe_m = 1;
        else if (q_m.size() < 16) q_m.push_back(b);
        else                    ovr_m = 1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        read = 1'b1;
        addr = a;
        @(negedge clk);
        read = 1'b0;
        d = rdata;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        writeb = be;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        writeb = '0;
        if (be[0] && a == 8'd1) begin
            if (d[2]) ovr_m = 0;
            if (d[3]) fe_m = 0;
        end
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d;
        bus_read(8'd1, d);
        chk(tag, d, exp_status());
    endtask

    task automatic chk_data(input string tag);
        logic [31:0] d, e;
        e = (q_m.size() != 0) ? {24'd0, q_m.pop_front()} : 32'd0;
        bus_read(8'd0, d);
        chk(tag, d, e);
    endtask

    task automatic chk_irq(input string tag);
        repeat (2) @(negedge clk);
        chk(tag, {31'd0, irq}, {31'd0, q_m.size() != 0});
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk_status("reset_status");

        // Single clean frame.
        send_frame(8'hA5, 1);
        chk_status("a5_status");
        chk("a5_status_const", exp_status(), 32'h0000_0101);
        chk_irq("a5_irq_set");
        chk_data("a5_data");
        chk_status("a5_status_empty");
        chk_irq("a5_irq_clear");

        // Short low glitch on an idle line.
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        chk_status("glitch_status");
        chk_data("glitch_data_empty");

        // Framing error and its clear; a write without byte 0 enabled must not clear.
        send_frame(8'h3C, 0);
        chk_status("fe_status");
        bus_write(8'd1, 4'b0010, 32'h8);
        chk_status("fe_no_clear_wrong_be");
        bus_write(8'd2, 4'b0001, 32'h8);
        chk_status("fe_no_clear_wrong_addr");
        bus_write(8'd1, 4'b0001, 32'h8);
        chk_status("fe_cleared");

        // Overrun: seventeen frames with no reads.
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1);
        chk_status("ovr_full_status");
        chk_irq("ovr_irq");
        for (int i = 0; i < 16; i++) chk_data($sformatf("ovr_data_%0d", i));
        chk_data("ovr_data_empty");
        chk_status("ovr_after_drain");
        bus_write(8'd1, 4'b0001, 32'h4);
        chk_status("ovr_cleared");

        // Pop landing in the same cycle as the stop-bit push.
        for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1);
        chk_status("simul_pre_status");
        b = 8'($urandom_range(0, 255));
        fork
            send_frame(b, 1);
            begin
                logic [31:0] e;
                repeat (610) @(negedge clk);
                e = {24'd0, q_m.pop_front()};
                bus_read(8'd0, d);
                chk("simul_pop_data", d, e);
            end
        join
        chk_status("simul_post_status");
        for (int i = 0; i < 3; i++) chk_data($sformatf("simul_order_%0d", i));

        // Randomised frames, flag clears and reads.
        for (int i = 0; i < 10; i++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 2) == 0)
                bus_write(8'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 32'($urandom));
            chk_status($sformatf("rand_status_%0d", i));
            if ($urandom_range(0, 1) == 1) chk_data($sformatf("rand_data_%0d", i));
        end
        while (q_m.size() != 0) chk_data("rand_drain");
        bus_write(8'd1, 4'b0001, 32'hC);
        chk_status("rand_final_status");

        // Reset in the middle of a frame's data bits leaves nothing behind.
        send_frame(8'h77, 1);
        chk_data("pre_reset_data");
        b = 8'h55;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q_m.delete();
        ovr_m = 0;
        fe_m  = 0;
        repeat (20) @(negedge clk);
        chk("midreset_rdata", rdata, 32'd0);
        chk("midreset_irq", {31'd0, irq}, 32'd0);
        chk_status("midreset_status");
        send_frame(8'h12, 1);
        chk_status("post_reset_status");
        chk_data("post_reset_data");
        chk_status("post_reset_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
